// File: rtl/morse_pkg.sv
// Shared constants, state encoding and entry type for the Morse message path.
package morse_pkg;

    localparam int CODE_W  = 8;
    localparam int LEN_W   = 4;
    localparam int MAX_LEN = 8;

    // A charlen of zero is the word-space character.
    localparam logic [LEN_W-1:0] LEN_SPACE = '0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESENT   = 3'd1,
        S_WAIT_NEXT = 3'd2,
        S_GAP       = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } entry_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/morse_msg_mem.sv
// Message store: DEPTH x 12-bit register file with append-only write,
// asynchronous read and fill count.
import morse_pkg::*;

module morse_msg_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  entry_t        wr_data,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output entry_t        rd_data,
    output logic [AW:0]   count,
    output logic          full
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + 1'b1;
        end
    end

    assign rd_data = mem[rd_addr];
    assign full    = (count == DEPTH_C);

endmodule

// File: rtl/morse_msg_sequencer.sv
// Message-level controller: buffers characters and plays them to the encoder
// over char_vald/char_next. Define MORSE_SEQ_LOOP_EN to add the loop input.
import morse_pkg::*;

module morse_msg_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
`ifdef MORSE_SEQ_LOOP_EN
    input  logic              loop,
`endif
    input  logic              char_next,
    output logic              char_vald,
    output logic [CODE_W-1:0] charcode,
    output logic [LEN_W-1:0]  charlen,
    output logic              busy,
    output logic              done,
    output logic              wr_drop,
    output logic [AW:0]       count,
    output logic              full
);

    state_t        state, state_nxt;
    logic [AW-1:0] rd_idx, rd_idx_nxt;
    logic [AW:0]   play_cnt, play_cnt_nxt;
    logic          load_char;
    logic          done_nxt;
    logic          done_q;
    logic          wr_drop_q;
    logic          wr_accept;
    logic          clear_ok;
    logic          last_char;
    logic          loop_again;
    entry_t        wr_data;
    entry_t        rd_data;

    assign wr_accept = wr_en && (state == S_IDLE) && !full && !clear;
    assign clear_ok  = clear && (state == S_IDLE);
    assign wr_data   = '{code: wr_code, len: clamp_len(wr_len)};

    // play_cnt is the count latched at start, so a same-cycle write is not played.
    assign last_char = ({1'b0, rd_idx} == (play_cnt - 1'b1));

`ifdef MORSE_SEQ_LOOP_EN
    assign loop_again = loop;
`else
    assign loop_again = 1'b0;
`endif

    morse_msg_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_data (wr_data),
        .clear   (clear_ok),
        .rd_addr (rd_idx),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_idx_nxt   = rd_idx;
        play_cnt_nxt = play_cnt;
        load_char    = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        rd_idx_nxt   = '0;
                        play_cnt_nxt = count;
                        state_nxt    = S_PRESENT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_PRESENT: begin
                load_char = 1'b1;
                state_nxt = S_WAIT_NEXT;
            end
            S_WAIT_NEXT: begin
                if (char_next) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (last_char && !loop_again) begin
                    state_nxt = S_FINISH;
                    done_nxt  = 1'b1;
                end else if (last_char) begin
                    rd_idx_nxt = '0;
                    state_nxt  = S_PRESENT;
                end else begin
                    rd_idx_nxt = rd_idx + 1'b1;
                    state_nxt  = S_PRESENT;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // abort overrides whatever the state logic chose, including char_next.
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            load_char = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx    <= '0;
            play_cnt  <= '0;
            charcode  <= '0;
            charlen   <= LEN_SPACE;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            rd_idx    <= rd_idx_nxt;
            play_cnt  <= play_cnt_nxt;
            done_q    <= done_nxt;
            wr_drop_q <= wr_en && !wr_accept;
            if (load_char) begin
                charcode <= rd_data.code;
                charlen  <= rd_data.len;
            end
        end
    end

    assign char_vald = (state == S_WAIT_NEXT);
    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Self-checking bench for morse_msg_sequencer against a queue-based message model.
module tb_morse_msg_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic       clk = 1'b0;
    logic       reset, wr_en, clear, start, abort, char_next;
    logic [7:0] wr_code;
    logic [3:0] wr_len;
`ifdef MORSE_SEQ_LOOP_EN
    logic       loop;
`endif
    logic       char_vald, busy, done, wr_drop, full;
    logic [7:0] charcode;
    logic [3:0] charlen;
    logic [AW:0] count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [11:0] model[$];
    logic [7:0]  cap_code[64];
    logic [3:0]  cap_len[64];
    int          cap_n, cap_done, cap_lat_bad, cap_unstable, cap_busy;
    bit          cap_timeout;

    morse_msg_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_code   (wr_code),
        .wr_len    (wr_len),
        .clear     (clear),
        .start     (start),
        .abort     (abort),
`ifdef MORSE_SEQ_LOOP_EN
        .loop      (loop),
`endif
        .char_next (char_next),
        .char_vald (char_vald),
        .charcode  (charcode),
        .charlen   (charlen),
        .busy      (busy),
        .done      (done),
        .wr_drop   (wr_drop),
        .count     (count),
        .full      (full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model.delete();
    endtask

    // Model: a write is kept only if the message has room; length clamps to 8.
    task automatic do_write(input logic [7:0] c, input logic [3:0] l, output bit accepted);
        accepted = (model.size() < DEPTH);
        if (accepted) model.push_back({c, (l > 4'd8) ? 4'd8 : l});
        wr_en = 1'b1; wr_code = c; wr_len = l;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_vald(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (char_vald === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Pulses start, answers each character after `delay` cycles (random if <0),
    // records characters and latency violations until done or a cycle budget.
    task automatic play(input int delay, input bit with_wr, input logic [7:0] wc, input logic [3:0] wl);
        int  wait_cnt, set_cyc;
        bit  prev_v;
        logic [7:0] hold_c;
        logic [3:0] hold_l;
        cap_n = 0; cap_done = 0; cap_lat_bad = 0; cap_unstable = 0; cap_busy = 0; cap_timeout = 1'b1;
        wait_cnt = 0; set_cyc = 0; prev_v = 1'b0; hold_c = '0; hold_l = '0;
        start = 1'b1;
        if (with_wr) begin
            wr_en = 1'b1; wr_code = wc; wr_len = wl;
        end
        tick();
        start = 1'b0; wr_en = 1'b0;
        for (int cyc = 1; cyc < 600; cyc++) begin
            if (busy === 1'b1) cap_busy++;
            if (char_vald === 1'b1 && !prev_v) begin
                if (cap_n < 64) begin
                    cap_code[cap_n] = charcode;
                    cap_len[cap_n]  = charlen;
                end
                if (cyc != ((cap_n == 0) ? 2 : set_cyc + 3)) cap_lat_bad++;
                cap_n++;
                hold_c = charcode; hold_l = charlen;
                wait_cnt = (delay < 0) ? int'($urandom_range(0, 6)) : delay;
            end
            if (char_vald === 1'b1 && (charcode !== hold_c || charlen !== hold_l)) cap_unstable++;
            char_next = 1'b0;
            if (char_vald === 1'b1) begin
                if (wait_cnt == 0) begin
                    char_next = 1'b1;
                    set_cyc = cyc;
                end else begin
                    wait_cnt--;
                end
            end
            prev_v = (char_vald === 1'b1);
            if (done === 1'b1) begin
                cap_done++;
                cap_timeout = 1'b0;
                char_next = 1'b0;
                tick();
                break;
            end
            tick();
        end
        char_next = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({char_vald, busy, done, wr_drop, full} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {char_vald, busy, done, wr_drop, full});
        end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if ({charcode, charlen} !== 12'h000) begin
            errors++; $display("FAIL reset_char got=%h exp=000", {charcode, charlen});
        end
    endtask

    task automatic test_basic();
        bit acc;
        reset_dut();
        do_write(8'hA0, 4'd2, acc);
        do_write(8'h00, 4'd0, acc);
        do_write(8'hC0, 4'd3, acc);
        checks++;
        if (count !== 4'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
        play(5, 1'b0, 8'h00, 4'h0);
        checks++;
        if (cap_timeout || cap_n != 3) begin errors++; $display("FAIL basic_nchars got=%0d exp=3 timeout=%0d", cap_n, cap_timeout); end
        for (int i = 0; i < 3 && i < cap_n; i++) begin
            checks++;
            if ({cap_code[i], cap_len[i]} !== model[i]) begin
                errors++; $display("FAIL basic_char%0d got=%h exp=%h", i, {cap_code[i], cap_len[i]}, model[i]);
            end
        end
        checks++;
        if (cap_lat_bad != 0 || cap_unstable != 0) begin
            errors++; $display("FAIL basic_timing got lat_bad=%0d unstable=%0d exp=0", cap_lat_bad, cap_unstable);
        end
        checks++;
        if (cap_done != 1 || busy !== 1'b0 || count !== 4'd3) begin
            errors++; $display("FAIL basic_end got done=%0d busy=%b count=%0d exp=1,0,3", cap_done, busy, count);
        end
    endtask

    task automatic test_overflow();
        bit acc;
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            do_write(8'($urandom), (i == 2) ? 4'hF : 4'($urandom), acc);
            checks++;
            if (wr_drop !== 1'b0) begin errors++; $display("FAIL ovf_drop%0d got=%b exp=0", i, wr_drop); end
        end
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL ovf_full got count=%0d full=%b exp=8,1", count, full); end
        do_write(8'h55, 4'd1, acc);
        checks++;
        if (wr_drop !== 1'b1 || acc) begin errors++; $display("FAIL ovf_9th got=%b exp=1", wr_drop); end
        tick();
        checks++;
        if (wr_drop !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL ovf_after got drop=%b count=%0d exp=0,8", wr_drop, count); end
        play(0, 1'b0, 8'h00, 4'h0);
        checks++;
        if (cap_n != DEPTH) begin errors++; $display("FAIL ovf_nchars got=%0d exp=%0d", cap_n, DEPTH); end
        for (int i = 0; i < DEPTH && i < cap_n; i++) begin
            checks++;
            if ({cap_code[i], cap_len[i]} !== model[i]) begin
                errors++; $display("FAIL ovf_char%0d got=%h exp=%h", i, {cap_code[i], cap_len[i]}, model[i]);
            end
        end
        checks++;
        if (cap_len[2] !== 4'd8) begin errors++; $display("FAIL ovf_clamp got=%0d exp=8", cap_len[2]); end
    endtask

    task automatic test_empty_start();
        reset_dut();
        play(0, 1'b0, 8'h00, 4'h0);
        checks++;
        if (cap_done != 1 || cap_n != 0 || cap_busy != 0) begin
            errors++; $display("FAIL empty_start got done=%0d chars=%0d busy_cycles=%0d exp=1,0,0", cap_done, cap_n, cap_busy);
        end
    endtask

    task automatic test_abort();
        bit acc, ok;
        int d0, bad;
        reset_dut();
        for (int i = 0; i < 3; i++) do_write(8'($urandom), 4'($urandom_range(0, 8)), acc);
        start = 1'b1; tick(); start = 1'b0;
        wait_vald(ok);
        char_next = 1'b1; tick(); char_next = 1'b0;
        wait_vald(ok);
        checks++;
        if (!ok || {charcode, charlen} !== model[1]) begin
            errors++; $display("FAIL abort_reach got=%h exp=%h ok=%0d", {charcode, charlen}, model[1], ok);
        end
        d0 = done_cnt;
        abort = 1'b1; char_next = 1'b1;
        tick();
        abort = 1'b0; char_next = 1'b0;
        checks++;
        if (busy !== 1'b0 || char_vald !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b vald=%b exp=0,0", busy, char_vald); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (char_vald !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || done_cnt != d0 || count !== 4'd3) begin
            errors++; $display("FAIL abort_quiet got bad=%0d dones=%0d count=%0d exp=0,0,3", bad, done_cnt - d0, count);
        end
        play(-1, 1'b0, 8'h00, 4'h0);
        checks++;
        if (cap_n != 3 || cap_done != 1) begin errors++; $display("FAIL abort_replay got chars=%0d done=%0d exp=3,1", cap_n, cap_done); end
        for (int i = 0; i < 3 && i < cap_n; i++) begin
            checks++;
            if ({cap_code[i], cap_len[i]} !== model[i]) begin
                errors++; $display("FAIL abort_char%0d got=%h exp=%h", i, {cap_code[i], cap_len[i]}, model[i]);
            end
        end
    endtask

    task automatic test_busy_ops();
        bit acc, ok;
        reset_dut();
        do_write(8'h11, 4'd1, acc);
        do_write(8'h22, 4'd2, acc);
        start = 1'b1; tick(); start = 1'b0;
        wait_vald(ok);
        wr_en = 1'b1; wr_code = 8'h33; wr_len = 4'd3;
        tick();
        wr_en = 1'b0;
        checks++;
        if (!ok || wr_drop !== 1'b1 || count !== 4'd2) begin
            errors++; $display("FAIL busy_write got drop=%b count=%0d exp=1,2", wr_drop, count);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (count !== 4'd2 || wr_drop !== 1'b0 || char_vald !== 1'b1) begin
            errors++; $display("FAIL busy_clear got count=%0d drop=%b vald=%b exp=2,0,1", count, wr_drop, char_vald);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        model.delete();
        checks++;
        if ({char_vald, busy, done, wr_drop, full, count, charcode, charlen} !== '0) begin
            errors++; $display("FAIL mid_reset got vald=%b busy=%b count=%0d char=%h exp=all zero",
                               char_vald, busy, count, {charcode, charlen});
        end
    endtask

    task automatic test_write_start();
        bit acc;
        reset_dut();
        do_write(8'h81, 4'd4, acc);
        do_write(8'h42, 4'd5, acc);
        model.push_back({8'h93, 4'd6});
        play(2, 1'b1, 8'h93, 4'd6);
        checks++;
        if (cap_n != 2 || count !== 4'd3) begin errors++; $display("FAIL wrstart_first got chars=%0d count=%0d exp=2,3", cap_n, count); end
        play(1, 1'b0, 8'h00, 4'h0);
        checks++;
        if (cap_n != 3) begin errors++; $display("FAIL wrstart_second got chars=%0d exp=3", cap_n); end
        for (int i = 0; i < 3 && i < cap_n; i++) begin
            checks++;
            if ({cap_code[i], cap_len[i]} !== model[i]) begin
                errors++; $display("FAIL wrstart_char%0d got=%h exp=%h", i, {cap_code[i], cap_len[i]}, model[i]);
            end
        end
    endtask

    task automatic test_random();
        bit acc;
        int n, bad;
        for (int it = 0; it < 8; it++) begin
            clear = 1'b1; tick(); clear = 1'b0;
            model.delete();
            checks++;
            if (count !== '0) begin errors++; $display("FAIL rnd_clear it=%0d got=%0d exp=0", it, count); end
            n = int'($urandom_range(0, 10));
            bad = 0;
            for (int k = 0; k < n; k++) begin
                do_write(8'($urandom), 4'($urandom), acc);
                if (wr_drop !== !acc || count !== (AW+1)'(model.size())) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rnd_writes it=%0d got bad=%0d exp=0", it, bad); end
            play(-1, 1'b0, 8'h00, 4'h0);
            checks++;
            if (cap_n != model.size() || cap_done != 1 || cap_lat_bad != 0 || cap_unstable != 0) begin
                errors++; $display("FAIL rnd_play it=%0d got chars=%0d done=%0d lat=%0d unst=%0d exp=%0d,1,0,0",
                                   it, cap_n, cap_done, cap_lat_bad, cap_unstable, model.size());
            end
            bad = 0;
            for (int i = 0; i < model.size() && i < cap_n; i++)
                if ({cap_code[i], cap_len[i]} !== model[i]) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rnd_data it=%0d got bad=%0d exp=0", it, bad); end
        end
    endtask

`ifdef MORSE_SEQ_LOOP_EN
    task automatic test_loop();
        bit acc, ok;
        int d0, bad;
        reset_dut();
        do_write(8'hE1, 4'd3, acc);
        do_write(8'h5A, 4'd7, acc);
        loop = 1'b1;
        d0 = done_cnt;
        bad = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_vald(ok);
            if (!ok || {charcode, charlen} !== model[i % 2]) bad++;
            if (i == 3) loop = 1'b0;
            char_next = 1'b1; tick(); char_next = 1'b0;
            if (i == 3) begin
                tick();
                if (done_cnt != d0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL loop_seq got bad=%0d exp=0", bad); end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (done_cnt - d0 != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL loop_running got dones=%0d busy=%b exp=0,1", done_cnt - d0, busy);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_vald(ok);
        char_next = 1'b1; tick(); char_next = 1'b0;
        wait_vald(ok);
        loop = 1'b0;
        char_next = 1'b1; tick(); char_next = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL loop_stop got dones=%0d busy=%b exp=1,0", done_cnt - d0, busy);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; clear = 1'b0; start = 1'b0; abort = 1'b0; char_next = 1'b0;
        wr_code = '0; wr_len = '0;
`ifdef MORSE_SEQ_LOOP_EN
        loop = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overflow();
        test_empty_start();
        test_abort();
        test_busy_ops();
        test_write_start();
        test_random();
`ifdef MORSE_SEQ_LOOP_EN
        test_loop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
